// File: rtl/instr_prefetch_pkg.sv
// Shared constants and FSM encoding for the instruction prefetch stage.
package instr_prefetch_pkg;

    // Datapath width shared by instructions, addresses and memory data.
    localparam int WORD_SIZE = 16;

    // Default number of prefetch queue entries.
    localparam int FETCH_DEPTH = 4;

    // Default first fetch address after reset.
    localparam logic [WORD_SIZE-1:0] RESET_PC = 16'h0000;

    // Prefetch FSM states.
    typedef enum logic [1:0] {
        PF_IDLE  = 2'b00,
        PF_REQ   = 2'b01,
        PF_DRAIN = 2'b10
    } pf_state_t;

endpackage

// File: rtl/instr_prefetch_fetch_queue.sv
// Circular buffer of {pc, instr} entries feeding the decoder. The head
// entry is held in registers so the outputs never depend combinationally
// on the push data. Flush wins over push and pop.
module fetch_queue #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WORD_SIZE-1:0]   push_pc,
    input  logic [WORD_SIZE-1:0]   push_instr,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WORD_SIZE-1:0]   head_pc,
    output logic [WORD_SIZE-1:0]   head_instr,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    logic [WORD_SIZE-1:0] pc_mem    [DEPTH];
    logic [WORD_SIZE-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_next_s;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_after_pop_s;
    logic [CNT_W-1:0]     count_next_s;
    logic                 valid_r;
    logic [WORD_SIZE-1:0] head_pc_r;
    logic [WORD_SIZE-1:0] head_instr_r;
    logic [WORD_SIZE-1:0] head_pc_next_s;
    logic [WORD_SIZE-1:0] head_instr_next_s;
    logic                 do_push_s;
    logic                 do_pop_s;

    // Qualify push/pop, compute next occupancy and the entry that becomes the head.
    always_comb begin
        do_push_s         = push && (count_r != FULL_C) && !flush;
        do_pop_s          = pop && (count_r != CNT_W'(0)) && !flush;
        rd_ptr_next_s     = do_pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        count_after_pop_s = count_r - CNT_W'(do_pop_s);
        head_pc_next_s    = head_pc_r;
        head_instr_next_s = head_instr_r;
        if (flush) begin
            count_next_s = CNT_W'(0);
        end else begin
            count_next_s = count_after_pop_s + CNT_W'(do_push_s);
        end
        if (flush) begin
            head_pc_next_s    = head_pc_r;
            head_instr_next_s = head_instr_r;
        end else if (count_after_pop_s == CNT_W'(0)) begin
            // Queue empties this cycle: the incoming word (if any) becomes the head.
            if (do_push_s) begin
                head_pc_next_s    = push_pc;
                head_instr_next_s = push_instr;
            end else begin
                head_pc_next_s    = head_pc_r;
                head_instr_next_s = head_instr_r;
            end
        end else begin
            head_pc_next_s    = pc_mem[rd_ptr_next_s];
            head_instr_next_s = instr_mem[rd_ptr_next_s];
        end
    end

    // Entry storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            pc_mem[wr_ptr_r]    <= push_pc;
            instr_mem[wr_ptr_r] <= push_instr;
        end
    end

    // Pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r     <= PTR_W'(0);
            rd_ptr_r     <= PTR_W'(0);
            count_r      <= CNT_W'(0);
            valid_r      <= 1'b0;
            head_pc_r    <= WORD_SIZE'(0);
            head_instr_r <= WORD_SIZE'(0);
        end else begin
            if (flush) begin
                wr_ptr_r <= PTR_W'(0);
                rd_ptr_r <= PTR_W'(0);
            end else begin
                if (do_push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                rd_ptr_r <= rd_ptr_next_s;
            end
            count_r      <= count_next_s;
            valid_r      <= (count_next_s != CNT_W'(0));
            head_pc_r    <= head_pc_next_s;
            head_instr_r <= head_instr_next_s;
        end
    end

    assign head_pc    = head_pc_r;
    assign head_instr = head_instr_r;
    assign valid      = valid_r;
    assign count      = count_r;

endmodule

// File: rtl/instr_prefetch.sv
// Decoupled instruction prefetch: issues sequential word reads with at most
// one request outstanding, queues returned words with their addresses, and
// flushes/restarts on redirect without ever abandoning a live memory request.
module instr_prefetch #(
    parameter int                   WORD_SIZE = instr_prefetch_pkg::WORD_SIZE,
    parameter int                   DEPTH     = instr_prefetch_pkg::FETCH_DEPTH,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(instr_prefetch_pkg::RESET_PC)
) (
    input  logic                   clk,
    input  logic                   do_reset,
    output logic                   mem_req,
    output logic [WORD_SIZE-1:0]   mem_addr,
    input  logic                   mem_ack,
    input  logic [WORD_SIZE-1:0]   mem_data,
    output logic [WORD_SIZE-1:0]   instr,
    output logic [WORD_SIZE-1:0]   instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_take,
    input  logic                   redirect,
    input  logic [WORD_SIZE-1:0]   redirect_pc,
    output logic [$clog2(DEPTH):0] count
);

    import instr_prefetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

    pf_state_t            state_r;
    pf_state_t            state_next_s;
    logic [WORD_SIZE-1:0] fetch_pc_r;
    logic [WORD_SIZE-1:0] fetch_pc_next_s;
    logic                 mem_req_r;
    logic [WORD_SIZE-1:0] mem_addr_r;
    logic [WORD_SIZE-1:0] mem_addr_next_s;
    logic                 push_s;
    logic                 pop_s;
    logic [CNT_W-1:0]     count_s;
    logic [CNT_W-1:0]     count_next_s;
    logic                 room_s;
    logic                 instr_valid_s;

    // Queue handshakes and the occupancy the FSM uses to decide on a new request.
    always_comb begin
        push_s       = (state_r == PF_REQ) && mem_ack && !redirect;
        pop_s        = instr_valid_s && instr_take && !redirect;
        count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        room_s       = (count_next_s < FULL_C);
    end

    // Next-state logic; redirect overrides everything but keeps a live request alive.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            PF_IDLE: begin
                if (redirect) begin
                    state_next_s = PF_IDLE;
                end else if (room_s) begin
                    state_next_s = PF_REQ;
                end else begin
                    state_next_s = PF_IDLE;
                end
            end
            PF_REQ: begin
                if (redirect) begin
                    state_next_s = mem_ack ? PF_IDLE : PF_DRAIN;
                end else if (mem_ack) begin
                    state_next_s = room_s ? PF_REQ : PF_IDLE;
                end else begin
                    state_next_s = PF_REQ;
                end
            end
            PF_DRAIN: begin
                if (mem_ack) begin
                    state_next_s = PF_IDLE;
                end else begin
                    state_next_s = PF_DRAIN;
                end
            end
            default: begin
                state_next_s = PF_IDLE;
            end
        endcase
    end

    // Next fetch address and the address presented to memory; the latter is
    // frozen while a discarded request is still waiting for its ack.
    always_comb begin
        if (redirect) begin
            fetch_pc_next_s = redirect_pc;
        end else if (push_s) begin
            fetch_pc_next_s = fetch_pc_r + WORD_SIZE'(1);
        end else begin
            fetch_pc_next_s = fetch_pc_r;
        end
        if (state_next_s == PF_DRAIN) begin
            mem_addr_next_s = mem_addr_r;
        end else begin
            mem_addr_next_s = fetch_pc_next_s;
        end
    end

    // FSM state, fetch address and registered memory-port outputs.
    always_ff @(posedge clk or posedge do_reset) begin
        if (do_reset) begin
            state_r    <= PF_IDLE;
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            mem_req_r  <= (state_next_s != PF_IDLE);
            mem_addr_r <= mem_addr_next_s;
        end
    end

    fetch_queue #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (do_reset),
        .push       (push_s),
        .push_pc    (mem_addr_r),
        .push_instr (mem_data),
        .pop        (pop_s),
        .flush      (redirect),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .valid      (instr_valid_s),
        .count      (count_s)
    );

    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign instr_valid = instr_valid_s;
    assign count       = count_s;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch with a transaction-level reference model
// (request/queue abstraction) checked every cycle, plus literal expectations.
module tb_instr_prefetch;

    logic        clk;
    logic        do_reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_take;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_prefetch #(
        .WORD_SIZE (16),
        .DEPTH     (4),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk         (clk),
        .do_reset    (do_reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_take  (instr_take),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ack after 'lat' waiting cycles, data = ~address.
    int lat = 0;
    int wait_cnt;
    always @(posedge clk or posedge do_reset) begin
        if (do_reset) wait_cnt <= 0;
        else if (mem_req && mem_ack) wait_cnt <= 0;
        else if (mem_req) wait_cnt <= wait_cnt + 1;
    end
    assign mem_ack  = mem_req && (wait_cnt >= lat);
    assign mem_data = ~mem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus one outstanding request that may be
    // marked as discarded after a redirect.
    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ins;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy;
    bit          m_disc;
    logic [15:0] m_addr;
    logic [15:0] m_pc;
    bit          model_en = 1'b0;
    logic        s_ack, s_take, s_redir;
    logic [15:0] s_rpc;
    logic [15:0] taken_log[$];
    logic [15:0] ack_log[$];

    task automatic model_init();
        m_q.delete();
        m_busy = 1'b0;
        m_disc = 1'b0;
        m_addr = 16'h0000;
        m_pc   = 16'h0000;
    endtask

    task automatic model_step();
        bit pop;
        pop = (m_q.size() > 0) && s_take && !s_redir;
        if (s_redir) begin
            m_q.delete();
            m_pc = s_rpc;
            if (m_busy && s_ack) begin
                m_busy = 1'b0;
                m_disc = 1'b0;
            end else if (m_busy) begin
                m_disc = 1'b1;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_busy && s_ack) begin
                if (m_disc) begin
                    m_busy = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_q.push_back('{pc: m_addr, ins: ~m_addr});
                    m_pc = m_pc + 16'd1;
                    if (m_q.size() < 4) m_addr = m_pc;
                    else m_busy = 1'b0;
                end
            end else if (!m_busy) begin
                if (m_q.size() < 4) begin
                    m_busy = 1'b1;
                    m_addr = m_pc;
                end
            end
        end
    endtask

    task automatic model_compare();
        check("mem_req", mem_req, m_busy);
        check("mem_addr", mem_addr, m_busy ? m_addr : m_pc);
        check("instr_valid", instr_valid, m_q.size() > 0);
        check("count", count, m_q.size());
        if (m_q.size() > 0) begin
            check("instr_pc", instr_pc, m_q[0].pc);
            check("instr", instr, m_q[0].ins);
        end
    endtask

    // Compare process: sample inputs before the edge, step model, check after.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            s_ack   = mem_ack;
            s_take  = instr_take;
            s_redir = redirect;
            s_rpc   = redirect_pc;
            if (model_en && instr_valid && instr_take && !redirect) taken_log.push_back(instr_pc);
            if (model_en && mem_req && mem_ack) ack_log.push_back(mem_addr);
            @(posedge clk);
            #1;
            if (model_en) begin
                model_step();
                model_compare();
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        do_reset    = 1'b1;
        instr_take  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        lat         = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_instr", instr, 16'h0000);
        check("rst_instr_pc", instr_pc, 16'h0000);
        do_reset = 1'b0;
        model_init();
        model_en = 1'b1;

        // Zero-wait fill without take.
        repeat (8) @(negedge clk);
        check("fill_count", count, 3'd4);
        check("fill_instr", instr, 16'hFFFF);
        check("fill_pc", instr_pc, 16'h0000);
        check("fill_req_low", mem_req, 1'b0);
        check("fill_ack_n", ack_log.size(), 4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) check("fill_ack_addr", ack_log[i], i);

        // Streaming with take held high.
        taken_log.delete();
        instr_take = 1'b1;
        repeat (10) @(negedge clk);
        instr_take = 1'b0;
        check("stream_n", taken_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < taken_log.size(); i++) check("stream_pc", taken_log[i], i);

        // Asynchronous reset pulse while a request is pending.
        lat = 3;
        instr_take = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("pre_reset_req", mem_req, 1'b1);
        @(posedge clk);
        #3;
        model_en = 1'b0;
        do_reset = 1'b1;
        #1;
        check("areset_req", mem_req, 1'b0);
        check("areset_valid", instr_valid, 1'b0);
        check("areset_count", count, 3'd0);
        check("areset_addr", mem_addr, 16'h0000);
        @(negedge clk);
        do_reset   = 1'b0;
        instr_take = 1'b0;
        model_init();
        taken_log.delete();
        ack_log.delete();
        model_en = 1'b1;
        @(negedge clk);
        check("restart_req", mem_req, 1'b1);
        check("restart_addr", mem_addr, 16'h0000);

        // Redirect while the request to 0x0003 is pending, then again in drain.
        for (int i = 0; i < 40 && !(mem_req && mem_addr == 16'h0003); i++) @(negedge clk);
        check("pend3_found", mem_addr, 16'h0003);
        redirect    = 1'b1;
        redirect_pc = 16'h0030;
        @(negedge clk);
        redirect = 1'b0;
        check("drain_valid", instr_valid, 1'b0);
        check("drain_addr", mem_addr, 16'h0003);
        check("drain_req", mem_req, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        check("drain_addr2", mem_addr, 16'h0003);
        for (int i = 0; i < 20 && !(mem_req && mem_addr != 16'h0003); i++) @(negedge clk);
        check("after_drain_addr", mem_addr, 16'h0040);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        check("after_drain_valid", instr_valid, 1'b1);
        check("after_drain_pc", instr_pc, 16'h0040);
        check("after_drain_instr", instr, 16'hFFBF);

        // Full queue: redirect and take in the same cycle.
        lat = 0;
        for (int i = 0; i < 30 && count != 3'd4; i++) @(negedge clk);
        check("full_count", count, 3'd4);
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        instr_take  = 1'b1;
        @(negedge clk);
        redirect   = 1'b0;
        instr_take = 1'b0;
        check("flush_count", count, 3'd0);
        check("flush_valid", instr_valid, 1'b0);
        for (int i = 0; i < 10 && !instr_valid; i++) @(negedge clk);
        check("flush_first_pc", instr_pc, 16'h0010);
        check("flush_first_instr", instr, 16'hFFEF);

        // Address wrap-around after redirect to 0xFFFE.
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        instr_take  = 1'b1;
        taken_log.delete();
        @(negedge clk);
        redirect = 1'b0;
        repeat (10) @(negedge clk);
        instr_take = 1'b0;
        check("wrap_n", taken_log.size() >= 4, 1'b1);
        if (taken_log.size() >= 4) begin
            check("wrap_pc0", taken_log[0], 16'hFFFE);
            check("wrap_pc1", taken_log[1], 16'hFFFF);
            check("wrap_pc2", taken_log[2], 16'h0000);
            check("wrap_pc3", taken_log[3], 16'h0001);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
